while_loop_sequencer: RTL



---
 rtl/while_pkg.sv | 14 +
 rtl/while_step_dp.sv | 17 +
 rtl/while_loop_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/while_pkg.sv
// Shared types and constants for the while-loop sequencer and its datapath.
package while_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        CALC = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int LOOP_STEP = 1;
    localparam int TEMP_INIT = 1;

endpackage : while_pkg

// File: rtl/while_step_dp.sv
// Combinational multiply-subtract step: (temp * a) truncated to NX bits, minus b.
module while_step_dp #(
    parameter int NX = 8
) (
    input  logic [NX-1:0] i_temp,
    input  logic [NX-1:0] i_a,
    input  logic [NX-1:0] i_b,
    output logic [NX-1:0] o_result
);

    // Low NX bits of the product equal the NX-bit truncation of the full 2NX-bit product.
    logic [NX-1:0] w_prod_lo;

    assign w_prod_lo = i_temp * i_a;
    assign o_result  = w_prod_lo - i_b;

endmodule : while_step_dp

// File: rtl/while_loop_sequencer.sv
// Handshaked sequencer: increments temp once per clock for COUNT cycles, then
// registers XOUT = (temp * A) - B and holds it until the consumer accepts.
module while_loop_sequencer
    import while_pkg::*;
#(
    parameter int NX   = 8,
    parameter int NCNT = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [NX-1:0]   A,
    input  logic [NX-1:0]   B,
    input  logic [NCNT-1:0] COUNT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [NX-1:0]   XOUT,
    output logic            BUSY
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NX-1:0]   r_a;
    logic [NX-1:0]   r_b;
    logic [NX-1:0]   r_temp;
    logic [NCNT-1:0] r_cnt;
    logic [NX-1:0]   r_xout;
    logic [NX-1:0]   w_dp_result;
    logic            w_accept;
    logic            w_loop_last;

    assign w_accept    = IN_VALID && (r_state == IDLE);
    assign w_loop_last = (r_cnt == NCNT'(1));

    while_step_dp #(
        .NX (NX)
    ) u_step_dp (
        .i_temp   (r_temp),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_dp_result)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (IN_VALID) begin
                    w_state_nxt = (COUNT != '0) ? LOOP : CALC;
                end
            end
            LOOP: begin
                if (w_loop_last) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (OUT_READY) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and loop body; everything clears so a reset discards the job.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a    <= '0;
            r_b    <= '0;
            r_temp <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a    <= A;
            r_b    <= B;
            r_cnt  <= COUNT;
            r_temp <= NX'(TEMP_INIT);
        end else if (r_state == LOOP) begin
            r_temp <= r_temp + NX'(LOOP_STEP);
            r_cnt  <= r_cnt - NCNT'(LOOP_STEP);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_xout <= '0;
        end else if (r_state == CALC) begin
            r_xout <= w_dp_result;
        end
    end

    assign XOUT      = r_xout;
    assign OUT_VALID = (r_state == HOLD);
    assign IN_READY  = (r_state == IDLE);
    assign BUSY      = (r_state != IDLE);

endmodule : while_loop_sequencer
